// File: rtl/crono_cuenta_regresiva.sv
// Countdown engine: shadows edited set values in EDIT, counts HH:MM:SS down to zero in RUN.
// Optional alarm auto-clear after ALARM_SECS ticks when CRONO_ALARM_TIMEOUT_EN is defined.
module crono_cuenta_regresiva #(
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] EN,
    input  logic [5:0] set_seg,
    input  logic [5:0] set_min,
    input  logic [4:0] set_hora,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       ack,
    output logic [5:0] cnt_seg,
    output logic [5:0] cnt_min,
    output logic [4:0] cnt_hora,
    output logic       running,
    output logic       alarma
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [5:0] seg_q, seg_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hora_q, hora_d;
    logic       alarma_q, alarma_d;
    logic       edit_mode;
    logic       count_zero;
    logic       alarm_set;

    if (ALARM_SECS < 1 || ALARM_SECS > 63) begin : gen_bad_alarm_secs
        $error("ALARM_SECS must be in 1..63");
    end

    assign edit_mode  = (EN != 2'd0);
    assign count_zero = (seg_q == 6'd0) && (min_q == 6'd0) && (hora_q == 5'd0);

`ifdef CRONO_ALARM_TIMEOUT_EN
    localparam logic [5:0] AlarmTicks = 6'(ALARM_SECS);
    logic [5:0] to_q, to_d;
`endif

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        min_d     = min_q;
        hora_d    = hora_q;
        alarma_d  = alarma_q;
        alarm_set = 1'b0;
`ifdef CRONO_ALARM_TIMEOUT_EN
        to_d      = to_q;
`endif
        if (edit_mode) begin
            // The editors can briefly present 60 (or >23 hours); those load as 0.
            seg_d    = (set_seg > 6'd59) ? 6'd0 : set_seg;
            min_d    = (set_min > 6'd59) ? 6'd0 : set_min;
            hora_d   = (set_hora > 5'd23) ? 5'd0 : set_hora;
            state_d  = StIdle;
            alarma_d = 1'b0;
        end else begin
            if (ack) begin
                alarma_d = 1'b0;
            end
`ifdef CRONO_ALARM_TIMEOUT_EN
            if (alarma_q && tick) begin
                to_d = to_q + 6'd1;
                if (to_q + 6'd1 >= AlarmTicks) begin
                    alarma_d = 1'b0;
                end
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (start_stop && !count_zero) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (start_stop) begin
                        state_d = StIdle;
                    end else if (tick) begin
                        if (seg_q != 6'd0) begin
                            seg_d = seg_q - 6'd1;
                        end else if (min_q != 6'd0) begin
                            seg_d = 6'd59;
                            min_d = min_q - 6'd1;
                        end else if (hora_q != 5'd0) begin
                            seg_d  = 6'd59;
                            min_d  = 6'd59;
                            hora_d = hora_q - 5'd1;
                        end
                        if (seg_d == 6'd0 && min_d == 6'd0 && hora_d == 5'd0) begin
                            state_d   = StIdle;
                            alarm_set = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
            // A fresh alarm overrides any same-cycle ack or timeout.
            if (alarm_set) begin
                alarma_d = 1'b1;
`ifdef CRONO_ALARM_TIMEOUT_EN
                to_d     = 6'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            seg_q    <= 6'd0;
            min_q    <= 6'd0;
            hora_q   <= 5'd0;
            alarma_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            min_q    <= min_d;
            hora_q   <= hora_d;
            alarma_q <= alarma_d;
        end
    end

`ifdef CRONO_ALARM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 6'd0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

    assign cnt_seg  = seg_q;
    assign cnt_min  = min_q;
    assign cnt_hora = hora_q;
    assign running  = (state_q == StRun);
    assign alarma   = alarma_q;

endmodule

// File: tb/tb_crono_cuenta_regresiva.sv
// Scoreboard bench for crono_cuenta_regresiva: stimulus pushes expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_crono_cuenta_regresiva;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] EN;
    logic [5:0] set_seg, set_min;
    logic [4:0] set_hora;
    logic       tick, start_stop, ack;
    logic [5:0] cnt_seg, cnt_min;
    logic [4:0] cnt_hora;
    logic       running, alarma;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic       r;
        logic       a;
    } exp_t;

    exp_t sb[$];

    crono_cuenta_regresiva #(.ALARM_SECS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .EN         (EN),
        .set_seg    (set_seg),
        .set_min    (set_min),
        .set_hora   (set_hora),
        .tick       (tick),
        .start_stop (start_stop),
        .ack        (ack),
        .cnt_seg    (cnt_seg),
        .cnt_min    (cnt_min),
        .cnt_hora   (cnt_hora),
        .running    (running),
        .alarma     (alarma)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (cnt_seg !== e.s || cnt_min !== e.m || cnt_hora !== e.h ||
                running !== e.r || alarma !== e.a) begin
                n_fail++;
                $display("FAIL %s: got %0d:%0d:%0d run=%b alm=%b, want %0d:%0d:%0d run=%b alm=%b",
                         e.name, cnt_hora, cnt_min, cnt_seg, running, alarma,
                         e.h, e.m, e.s, e.r, e.a);
            end
        end
    end

    // One clock cycle with the given inputs; returns just after the sampling edge.
    task automatic cyc(input logic [1:0] en, input logic [5:0] s, input logic [5:0] m,
                       input logic [4:0] h, input logic tk, input logic ss, input logic ak);
        EN = en; set_seg = s; set_min = m; set_hora = h;
        tick = tk; start_stop = ss; ack = ak;
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; ack = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [4:0] h, input logic [5:0] m,
                              input logic [5:0] s, input logic r, input logic a);
        exp_t e;
        e.name = name; e.s = s; e.m = m; e.h = h; e.r = r; e.a = a;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        expect_out("reset", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Edit load with clamping and exact boundaries.
        cyc(2'd2, 6'd60, 6'd5, 5'd30, 1'b0, 1'b1, 1'b0);
        expect_out("edit_clamp", 5'd0, 6'd5, 6'd0, 1'b0, 1'b0);
        cyc(2'd3, 6'd59, 6'd60, 5'd23, 1'b1, 1'b0, 1'b0);
        expect_out("edit_bounds", 5'd23, 6'd0, 6'd59, 1'b0, 1'b0);

        // Borrow chain from 01:00:00.
        cyc(2'd1, 6'd0, 6'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 6'd7, 6'd7, 5'd7, 1'b0, 1'b0, 1'b0);
        expect_out("leave_edit", 5'd1, 6'd0, 6'd0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_out("start", 5'd1, 6'd0, 6'd0, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("borrow_hr", 5'd0, 6'd59, 6'd59, 1'b1, 1'b0);
        for (int i = 0; i < 3597; i++) begin
            cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        end
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("one_left", 5'd0, 6'd0, 6'd1, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("reach_zero", 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("alarm_holds", 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_out("zero_start_alm", 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        expect_out("ack_clear", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_out("zero_start", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

        // Alarm set beats same-cycle ack; EDIT then clears and reloads.
        cyc(2'd1, 6'd2, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("tick_2_to_1", 5'd0, 6'd0, 6'd1, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        expect_out("set_beats_ack", 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        cyc(2'd1, 6'd7, 6'd8, 5'd9, 1'b0, 1'b0, 1'b0);
        expect_out("edit_clears", 5'd9, 6'd8, 6'd7, 1'b0, 1'b0);

        // Simultaneous start_stop and tick, plus pause/resume.
        cyc(2'd2, 6'd10, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_out("start_10", 5'd0, 6'd0, 6'd10, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        expect_out("stop_with_tick", 5'd0, 6'd0, 6'd10, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        expect_out("start_with_tick", 5'd0, 6'd0, 6'd10, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("first_dec", 5'd0, 6'd0, 6'd9, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("paused_tick", 5'd0, 6'd0, 6'd9, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("resume", 5'd0, 6'd0, 6'd8, 1'b1, 1'b0);

        // Borrow from minutes only.
        cyc(2'd1, 6'd0, 6'd3, 5'd2, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("borrow_min", 5'd2, 6'd2, 6'd59, 1'b1, 1'b0);

        // Reset mid-run at 00:12:34.
        cyc(2'd1, 6'd34, 6'd12, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_out("run_1234", 5'd0, 6'd12, 6'd34, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("rst_mid_run", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("tick_after_rst", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

`ifdef CRONO_ALARM_TIMEOUT_EN
        cyc(2'd1, 6'd1, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("to_alarm", 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        end
        expect_out("to_9_ticks", 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        cyc(2'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out("to_10th_tick", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
`endif

        // Give the monitor a bounded window to drain the scoreboard.
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
